// File: rtl/seven_segment_scanner_if.sv
// Digit bus between the time/mode logic, the scanner and the segment decoder / anode pins.
// blink_i exists only when SCAN_BLINK_EN is defined.
// No handshake: inputs are level-sampled once per slot, outputs are registered levels.
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   enable_i;
    logic [NUM_DIGITS-1:0]   dp_i;
`ifdef SCAN_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink_i;
`endif
    logic [3:0]              num_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    dp_o;
    logic [2:0]              idx_o;
    logic                    frame_o;

`ifdef SCAN_BLINK_EN
    modport master (output digits_i, enable_i, dp_i, blink_i,
                    input  num_o, an_o, dp_o, idx_o, frame_o);
    modport slave  (input  digits_i, enable_i, dp_i, blink_i,
                    output num_o, an_o, dp_o, idx_o, frame_o);
`else
    modport master (output digits_i, enable_i, dp_i,
                    input  num_o, an_o, dp_o, idx_o, frame_o);
    modport slave  (input  digits_i, enable_i, dp_i,
                    output num_o, an_o, dp_o, idx_o, frame_o);
`endif
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment scan controller; optional blink via SCAN_BLINK_EN.
// Latency: digit captured at end of each slot's blank gap, anode low on that same edge (registered).
// No backpressure: free-running scan, inputs sampled once per slot.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV          = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 64
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    seven_segment_scanner_if.slave  bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LATCH = CW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]            state;
    logic [CW-1:0]         cnt;
    logic [2:0]            idx;
    logic [3:0]            num_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  dp_q;
    logic                  frame_q;

    logic [3:0]            sel_num;
    logic                  sel_dp;
    logic                  sel_en;
    logic                  sel_blink;
    logic [NUM_DIGITS-1:0] sel_an;
    logic                  vis;
    logic                  slot_end;

    // Select the current digit's fields without a variable part-select.
    always_comb begin
        sel_num   = 4'h0;
        sel_dp    = 1'b0;
        sel_en    = 1'b0;
        sel_blink = 1'b0;
        sel_an    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == 3'(k)) begin
                sel_num   = bus.digits_i[4*k +: 4];
                sel_dp    = bus.dp_i[k];
                sel_en    = bus.enable_i[k];
`ifdef SCAN_BLINK_EN
                sel_blink = bus.blink_i[k];
`endif
                sel_an[k] = 1'b0;
            end
        end
    end

    assign slot_end = (state == ST_DRIVE) && (cnt == CNT_LAST);

`ifdef SCAN_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [FW-1:0] frame_cnt;
    logic          phase;

    // Phase flips on the wrap edge that completes every BLINK_DIV-th frame.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (slot_end && (idx == IDX_LAST)) begin
            if (frame_cnt == FW'(BLINK_DIV - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign vis = sel_en & ~(phase & sel_blink);
`else
    assign vis = sel_en & ~sel_blink;
`endif

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state   <= ST_BLANK;
            cnt     <= '0;
            idx     <= 3'd0;
            num_q   <= 4'h0;
            an_q    <= '1;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            case (state)
                ST_BLANK: begin
                    if (cnt == CNT_LATCH) begin
                        state <= ST_DRIVE;
                        num_q <= sel_num;
                        dp_q  <= ~sel_dp;
                        an_q  <= vis ? sel_an : '1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_BLANK;
                        an_q  <= '1;
                        dp_q  <= 1'b1;
                        if (idx == IDX_LAST) begin
                            idx     <= 3'd0;
                            frame_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

    assign bus.num_o   = num_q;
    assign bus.an_o    = an_q;
    assign bus.dp_o    = dp_q;
    assign bus.idx_o   = idx;
    assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: a time-arithmetic model pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_seven_segment_scanner;
    localparam int N    = 4;
    localparam int DIV  = 8;
    localparam int BL   = 2;
    localparam int BDIV = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    seven_segment_scanner_if #(.NUM_DIGITS(N)) bus();

    seven_segment_scanner #(
        .NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BL), .BLINK_DIV(BDIV)
    ) dut (
        .clk_i(clk),
        .resetn_i(resetn),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]   num;
        logic [N-1:0] an;
        logic         dp;
        logic [2:0]   idx;
        logic         frame;
        logic         rst;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the scan follows from the count of live clocks since reset.
    int         m_t = 0;
    int         m_frames = 0;
    logic [3:0] m_num = 4'h0;
    logic       m_dp = 1'b0;
    logic       m_vis = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        int cb, slot, ca;
        logic blk;
        logic [N-1:0] one;
        one = 1;
        if (!resetn) begin
            m_t = 0; m_frames = 0; m_num = 4'h0; m_dp = 1'b0; m_vis = 1'b0;
            e.num = 4'h0; e.an = '1; e.dp = 1'b1; e.idx = 3'd0; e.frame = 1'b0; e.rst = 1'b1;
        end else begin
            m_t++;
            cb   = (m_t - 1) % DIV;
            slot = ((m_t - 1) / DIV) % N;
            if (cb == BL - 1) begin
                blk = 1'b0;
`ifdef SCAN_BLINK_EN
                blk = bus.blink_i[slot];
`endif
                m_num = bus.digits_i[4*slot +: 4];
                m_dp  = bus.dp_i[slot];
                m_vis = bus.enable_i[slot] && !(((m_frames / BDIV) % 2 == 1) && blk);
            end
            ca      = m_t % DIV;
            e.rst   = 1'b0;
            e.frame = (m_t % (N*DIV)) == 0;
            if (e.frame) m_frames++;
            e.idx = 3'((m_t / DIV) % N);
            e.num = m_num;
            if (ca >= BL) begin
                e.an = m_vis ? ~(one << e.idx) : '1;
                e.dp = !m_dp;
            end else begin
                e.an = '1;
                e.dp = 1'b1;
            end
        end
        q.push_back(e);
    end

    int since = -1;
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("an_o", 32'(bus.an_o), 32'(e.an));
            chk("num_o", 32'(bus.num_o), 32'(e.num));
            chk("dp_o", 32'(bus.dp_o), 32'(e.dp));
            chk("idx_o", 32'(bus.idx_o), 32'(e.idx));
            chk("frame_o", 32'(bus.frame_o), 32'(e.frame));
            chk("an_one_cold", 32'($countones(~bus.an_o) <= 1), 32'd1);
            if (e.rst) since = -1;
            else if (since >= 0) since++;
            if (bus.frame_o === 1'b1) begin
                if (since >= 0) chk("frame_period", 32'(since), 32'(N*DIV));
                since = 0;
            end
        end
    end

    task automatic wait_drive(input logic [2:0] d, input logic [N-1:0] an, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.idx_o == d && bus.an_o == an) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out waiting for digit %0d drive", name, d);
        end
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        repeat (cycles) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        bus.digits_i = 16'h4321;
        bus.enable_i = 4'hF;
        bus.dp_i     = 4'h0;
`ifdef SCAN_BLINK_EN
        bus.blink_i  = 4'h0;
`endif
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (70) @(negedge clk);

        // Change digit 0 mid-drive: must not show until the next digit-0 slot.
        wait_drive(3'd0, 4'b1110, "tear_wait");
        repeat (2) @(negedge clk);
        bus.digits_i[3:0] = 4'h9;
        repeat (40) @(negedge clk);

        bus.enable_i = 4'b1011;
        bus.dp_i     = 4'b0001;
        repeat (40) @(negedge clk);

        // Reset during slot 2 drive.
        bus.enable_i = 4'hF;
        wait_drive(3'd2, 4'b1011, "reset_wait");
        repeat (2) @(negedge clk);
        do_reset(1);
        repeat (40) @(negedge clk);

`ifdef SCAN_BLINK_EN
        bus.blink_i = 4'b0010;
`endif
        do_reset(2);
        repeat (5 * N * DIV) @(negedge clk);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                bus.digits_i = 16'($urandom);
                bus.enable_i = 4'($urandom);
                bus.dp_i     = 4'($urandom);
`ifdef SCAN_BLINK_EN
                bus.blink_i  = 4'($urandom);
`endif
            end
            resetn = ($urandom_range(399) != 0);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed scan controller for the clock's multi-digit seven-segment display. It shares the single `seven_segment_decoder` among up to eight digits. It walks a digit index, captures that digit's nibble onto the decoder input, and drives the active-low anode for a fixed slot. Each slot begins with an anti-ghosting blank gap. The block sits between the timekeeping/mode logic, which supplies packed digit values, and the decoder plus board anode pins.

## Interface
Parameters:
- `NUM_DIGITS`, 8: number of scanned digits; legal range 2..8.
- `DIV`, 100000: clocks per digit slot, blank gap included; must satisfy `DIV > BLANK_CYCLES`.
- `BLANK_CYCLES`, 16: clocks at the start of each slot with all anodes off; must be ≥1.
- `BLINK_DIV`, 64: scan frames per blink half-period; only used with `SCAN_BLINK_EN`.

Ports:
- `clk_i`  in  1  system clock.
- `resetn_i`  in  1  reset. One clock; reset is synchronous and active-low.
- `digits_i`  in  4*NUM_DIGITS  packed BCD/hex values; digit k is `[4k+3:4k]`.
- `enable_i`  in  NUM_DIGITS  per-digit enable; 0 keeps that anode off for its whole slot.
- `dp_i`  in  NUM_DIGITS  per-digit decimal point request, active-high.
- `blink_i`  in  NUM_DIGITS  per-digit blink request. Present only with `SCAN_BLINK_EN`.
- `num_o`  out  4  nibble to `seven_segment_decoder.num_i`.
- `an_o`  out  NUM_DIGITS  anode selects, active-low, one-cold or all-high.
- `dp_o`  out  1  decimal point segment, active-low.
- `idx_o`  out  3  current digit index.
- `frame_o`  out  1  one-clock pulse when the index wraps to 0.

## Operation
- The FSM has two states, BLANK and DRIVE, plus a slot counter `cnt` (0..DIV-1) and an index `idx` (0..NUM_DIGITS-1).
- BLANK: `an_o` is all ones and `dp_o`=1. When `cnt`=BLANK_CYCLES-1, go to DRIVE. On that same edge, latch `num_o` ← digit `idx` of `digits_i`, latch the dp value, and latch the visibility. There is no mid-slot tearing: input changes during DRIVE do not appear until the next slot.
- DRIVE: `an_o[idx]`=0 if the latched visibility is 1; all other bits are 1. `dp_o`=~dp latched. When `cnt`=DIV-1, go to BLANK and reset `cnt` to 0.
  - `idx` increments, wrapping from NUM_DIGITS-1 to 0.
  - `frame_o` pulses on the wrap edge.
- Visibility is `enable_i[idx]` AND NOT blink-suppress, sampled at the latch edge.
- `an_o` is never driven with more than one zero bit.
- Reset mid-slot: all state returns to reset values on the next edge. The scan restarts at BLANK, `idx`=0, `cnt`=0.
- The decoder's own reset drives all segments on. The scanner's all-high `an_o` during reset keeps the display dark.

## Timing
- All outputs are registered.
- Reset values: `an_o`=all ones, `num_o`=0, `dp_o`=1, `idx_o`=0, `frame_o`=0. Internally, `cnt`=0, state=BLANK, blink phase=0.
- After reset release, the first anode falls on edge BLANK_CYCLES.
- The slot period is exactly DIV clocks, and the anode is low for DIV−BLANK_CYCLES clocks.
- The frame period is NUM_DIGITS·DIV clocks.
- `idx_o` updates on the same edge as the DRIVE→BLANK transition.
- `frame_o` is high for exactly one clock per frame, coincident with `idx_o` becoming 0.
- Decoder path latency is 0 beyond `num_o`. `num_o` is stable for the whole DRIVE interval and for the following BLANK.

## Configuration
- `SCAN_BLINK_EN` defined:
  - `blink_i` exists.
  - A frame counter toggles a blink phase every BLINK_DIV frames. Phase 0 = visible, and the toggle occurs at the `frame_o` edge.
  - When phase=1 and `blink_i[idx]`=1 at the latch edge, that slot's anode stays high.
- `SCAN_BLINK_EN` undefined:
  - `blink_i` port, frame counter and phase logic are removed.
  - Visibility = `enable_i[idx]` only.

## Test plan
Parameters for all scenarios unless stated: NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2, BLINK_DIV=2.
- Reset scan: `digits_i`=16'h4321 and all enabled, release reset.
  - `an_o`=4'b1111 for edges 0-1.
  - On edge 2, `an_o`=4'b1110 with `num_o`=1.
  - On edge 10, `an_o`=4'b1101 with `num_o`=2.
  - `frame_o` pulses once every 32 clocks.
- Tear-free latch: change `digits_i[3:0]` from 1 to 9 mid-DRIVE of digit 0. `num_o` stays 1 until the next digit-0 latch, then shows 9.
- Enable/dp: `enable_i`=4'b1011 and `dp_i`=4'b0001.
  - During slot 2, `an_o` stays 4'b1111.
  - During slot 0, `dp_o`=0; in other slots, `dp_o`=1.
- Reset mid-operation: assert `resetn_i` low during slot 2 DRIVE. On the next edge, `an_o`=all ones, `idx_o`=0 and `num_o`=0, and the scan restarts at digit 0.
- Blink (`SCAN_BLINK_EN`): `blink_i`=4'b0010.
  - Digit 1 is lit during frames 0-1.
  - Digit 1 is dark during frames 2-3.
  - The other digits are unaffected.
- Invariant checks, all runs: `an_o` never has more than one zero bit, and is never low during BLANK.
